serial_word_feeder_32_bit: RTL and testbench

Upstream feeder for the 32-bit serial-in-serial-out shift register. It accepts parallel words over a valid/ready handshake, buffers one word, and serialises each word into a serial bit plus a shift strobe. Those two outputs wire directly to the shift register's `Serial_Data_In` and `Shift_Data_Signal_In`. Back-to-back words stream with no idle cycle unless a configurable inter-word gap is requested.

---
 rtl/serial_feeder_pkg.sv | 12 +
 rtl/serial_word_feeder_32_bit.sv | 132 +++++++++++++
 tb/tb_serial_word_feeder_32_bit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_feeder_pkg.sv
// Shared types and defaults for the serial word feeder.
package serial_feeder_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/serial_word_feeder_32_bit.sv
// Parallel-to-serial feeder: one-word holding buffer behind a valid/ready port,
// serialised into a bit plus shift strobe for a downstream SISO shift register.
// DATA_WIDTH must be at least 2.
module serial_word_feeder_32_bit
  import serial_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic [DATA_WIDTH-1:0] Word_Data_In,
  input  logic                  Word_Valid_In,
  output logic                  Word_Ready_Out,
  output logic                  Serial_Data_Out,
  output logic                  Shift_Data_Signal_Out,
  output logic                  Word_Done_Out,
  output logic                  Busy_Out
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  feeder_state_e         state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] shift_adv;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  load;

  // Handshake and status outputs; the strobe and done pulse are gated by the enable
  assign Word_Ready_Out        = ~hold_valid_q;
  assign Serial_Data_Out       = (MSB_FIRST != 0) ? shift_q[DATA_WIDTH-1] : shift_q[0];
  assign Shift_Data_Signal_Out = (state_q == SHIFT) & Enable_In;
  assign Word_Done_Out         = Shift_Data_Signal_Out & (count_q == BIT_LAST);
  assign Busy_Out              = (state_q != IDLE) | hold_valid_q;

  // Shift word advanced by one bit toward the output end
  always_comb begin
    if (MSB_FIRST != 0) begin
      shift_adv = {shift_q[DATA_WIDTH-2:0], 1'b0};
    end else begin
      shift_adv = {1'b0, shift_q[DATA_WIDTH-1:1]};
    end
  end

  // Next-state logic: buffer fill ignores enable, everything else advances only when enabled
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    count_d      = count_q;
    gap_d        = gap_q;
    load         = 1'b0;

    if (Word_Valid_In && !hold_valid_q) begin
      hold_d       = Word_Data_In;
      hold_valid_d = 1'b1;
    end

    if (Enable_In) begin
      case (state_q)
        IDLE: begin
          if (hold_valid_q) begin
            load = 1'b1;
          end
        end
        SHIFT: begin
          if (count_q == BIT_LAST) begin
            if (GAP_CYCLES > 0) begin
              state_d = GAP;
              gap_d   = '0;
            end else if (hold_valid_q) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            count_d = count_q + CNT_W'(1);
            shift_d = shift_adv;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            if (hold_valid_q) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (load) begin
      state_d      = SHIFT;
      shift_d      = hold_q;
      count_d      = '0;
      hold_valid_d = 1'b0;
    end
  end

  // State registers; reset discards both the in-flight and the buffered word
  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      count_q      <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      count_q      <= count_d;
      gap_q        <= gap_d;
    end
  end

endmodule

// File: tb/tb_serial_word_feeder_32_bit.sv
// Bench for serial_word_feeder_32_bit: a default instance (MSB first, no gap)
// and a second instance with LSB-first order and a 3-cycle inter-word gap.
module tb_serial_word_feeder_32_bit;

  typedef struct {
    int   cyc;
    logic b;
    logic d;
  } rec_t;

  typedef struct {
    logic        valid;
    logic        en;
    logic [31:0] data;
    logic [4:0]  expOut;
  } vec_t;

  logic clk = 1'b0;
  int   cyc = 0;

  logic        rst0 = 1'b1, en0 = 1'b1, valid0 = 1'b0;
  logic [31:0] data0 = '0;
  logic        ready0, ser0, strobe0, done0, busy0;
  logic        rst1 = 1'b1, en1 = 1'b1, valid1 = 1'b0;
  logic [31:0] data1 = '0;
  logic        ready1, ser1, strobe1, done1, busy1;
  logic [4:0]  out0, out1;

  int          errors = 0;
  int          checks = 0;
  rec_t        q0[$], q1[$];
  logic [31:0] exp0[$], exp1[$];
  int          doneCnt0 = 0, doneCnt1 = 0;
  logic [31:0] sr0 = '0;
  logic        stopEn = 1'b0;
  vec_t        vecs[5];

  serial_word_feeder_32_bit #(.DATA_WIDTH(32), .MSB_FIRST(1), .GAP_CYCLES(0)) dut (
    .Clk_In(clk), .Reset_In(rst0), .Enable_In(en0), .Word_Data_In(data0),
    .Word_Valid_In(valid0), .Word_Ready_Out(ready0), .Serial_Data_Out(ser0),
    .Shift_Data_Signal_Out(strobe0), .Word_Done_Out(done0), .Busy_Out(busy0)
  );

  serial_word_feeder_32_bit #(.DATA_WIDTH(32), .MSB_FIRST(0), .GAP_CYCLES(3)) dutGap (
    .Clk_In(clk), .Reset_In(rst1), .Enable_In(en1), .Word_Data_In(data1),
    .Word_Valid_In(valid1), .Word_Ready_Out(ready1), .Serial_Data_Out(ser1),
    .Shift_Data_Signal_Out(strobe1), .Word_Done_Out(done1), .Busy_Out(busy1)
  );

  assign out0 = {ready0, strobe0, done0, busy0, ser0};
  assign out1 = {ready1, strobe1, done1, busy1, ser1};

  // Free-running clock and cycle counter used to time-stamp strobes
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobed bit, mimicking the downstream shift register's sampling
  always @(negedge clk) begin
    if (rst0 && strobe0) begin
      q0.push_back('{cyc, ser0, done0});
      sr0 = {sr0[30:0], ser0};
    end
    if (rst0 && done0) doneCnt0++;
    if (rst1 && strobe1) q1.push_back('{cyc, ser1, done1});
    if (rst1 && done1) doneCnt1++;
  end

  // Hard stop in case something hangs despite the bounded waits
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer one word and hold valid until the feeder takes it; returns at posedge+1
  task automatic applyStimulus(input int sel, input logic [31:0] w);
    int   n = 0;
    logic rdy;
    if (sel == 0) begin valid0 = 1'b1; data0 = w; exp0.push_back(w); end
    else          begin valid1 = 1'b1; data1 = w; exp1.push_back(w); end
    do begin
      @(negedge clk);
      rdy = (sel == 0) ? ready0 : ready1;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    checkOutput("word accepted within budget", rdy, 1);
    if (sel == 0) valid0 = 1'b0;
    else          valid1 = 1'b0;
  endtask

  task automatic waitIdle(input int sel);
    int   n = 0;
    logic b;
    do begin
      @(negedge clk);
      b = (sel == 0) ? busy0 : busy1;
      n++;
    end while (b && n < 3000);
    checkOutput("drained within budget", b, 0);
  endtask

  // Reference: the strobed bit stream is the sent words concatenated in bit order,
  // with a done flag on the last bit of every word and nowhere else
  task automatic checkStream(input string name, input int sel, input bit msb);
    rec_t        r;
    logic [31:0] w;
    logic        expB;
    int nRec, nWords, dc;
    int badBits = 0, badDone = 0;
    nRec   = (sel == 0) ? q0.size() : q1.size();
    nWords = (sel == 0) ? exp0.size() : exp1.size();
    dc     = (sel == 0) ? doneCnt0 : doneCnt1;
    checkOutput({name, " strobe count"}, nRec, nWords * 32);
    for (int i = 0; i < nRec && i < nWords * 32; i++) begin
      r    = (sel == 0) ? q0[i] : q1[i];
      w    = (sel == 0) ? exp0[i / 32] : exp1[i / 32];
      expB = msb ? w[31 - (i % 32)] : w[i % 32];
      if (r.b !== expB) badBits++;
      if (r.d !== ((i % 32) == 31)) badDone++;
    end
    checkOutput({name, " wrong bits"}, badBits, 0);
    checkOutput({name, " misplaced done"}, badDone, 0);
    checkOutput({name, " done pulses"}, dc, nWords);
  endtask

  task automatic clearScoreboard();
    q0.delete(); exp0.delete(); doneCnt0 = 0;
    q1.delete(); exp1.delete(); doneCnt1 = 0;
  endtask

  // Main sequence
  initial begin
    int n;
    int lowCnt;
    int stallStrobes;

    // outputs are {ready, strobe, done, busy, serial}
    vecs[0] = '{1'b1, 1'b1, 32'h8000_0001, 5'b00010};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0000, 5'b00010};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0000, 5'b11011};
    vecs[3] = '{1'b1, 1'b0, 32'h5555_AAAA, 5'b00011};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0000, 5'b01010};

    #1 rst0 = 1'b0; rst1 = 1'b0;
    #3;
    checkOutput("reset outputs default", out0, 5'b10000);
    checkOutput("reset outputs gap", out1, 5'b10000);
    repeat (3) @(posedge clk);
    #1 rst0 = 1'b1; rst1 = 1'b1;
    clearScoreboard();

    // Handshake / enable table from idle
    for (int i = 0; i < 5; i++) begin
      valid0 = vecs[i].valid;
      en0    = vecs[i].en;
      data0  = vecs[i].data;
      @(posedge clk);
      #1;
      checkOutput($sformatf("vector %0d outputs", i), out0, vecs[i].expOut);
    end
    valid0 = 1'b0;
    en0    = 1'b1;

    // Reset in mid-word with the buffer full
    n = 0;
    while (q0.size() < 8 && n < 100) begin @(negedge clk); n++; end
    checkOutput("reached bit 8 before reset", q0.size() >= 8, 1);
    @(posedge clk);
    #2 rst0 = 1'b0;
    #1 checkOutput("async reset outputs", out0, 5'b10000);
    @(negedge clk);
    checkOutput("held reset outputs", out0, 5'b10000);
    @(posedge clk);
    #1 rst0 = 1'b1;
    clearScoreboard();
    applyStimulus(0, 32'h0000_0001);
    waitIdle(0);
    repeat (10) @(negedge clk);
    checkStream("post-reset word", 0, 1'b1);

    // Single word, MSB first
    @(posedge clk);
    #1 clearScoreboard();
    sr0 = '0;
    applyStimulus(0, 32'hA5A5_0F0F);
    waitIdle(0);
    checkStream("single word", 0, 1'b1);
    checkOutput("single word contiguous", (q0.size() == 32) ? q0[31].cyc - q0[0].cyc : -1, 31);
    checkOutput("downstream register content", sr0, 32'hA5A5_0F0F);

    // Back-to-back with valid held high
    @(posedge clk);
    #1 clearScoreboard();
    applyStimulus(0, 32'hFFFF_FFFF);
    applyStimulus(0, 32'h0000_0000);
    lowCnt = 0;
    n = 0;
    do begin
      @(negedge clk);
      if (!ready0) lowCnt++;
      n++;
    end while (!ready0 && n < 100);
    checkOutput("ready low until reload", lowCnt, 31);
    waitIdle(0);
    checkStream("back-to-back", 0, 1'b1);
    checkOutput("back-to-back contiguous", (q0.size() == 64) ? q0[63].cyc - q0[0].cyc : -1, 63);

    // Enable stall after bit 10
    @(posedge clk);
    #1 clearScoreboard();
    applyStimulus(0, 32'h1234_5678);
    n = 0;
    while (q0.size() < 10 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 en0 = 1'b0;
    stallStrobes = 0;
    repeat (5) begin
      @(negedge clk);
      if (strobe0) stallStrobes++;
    end
    @(posedge clk);
    #1 en0 = 1'b1;
    checkOutput("strobes during stall", stallStrobes, 0);
    waitIdle(0);
    checkStream("enable stall", 0, 1'b1);

    // Random words, random valid spacing and random enable drops
    @(posedge clk);
    #1 clearScoreboard();
    stopEn = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          applyStimulus(0, $urandom());
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        stopEn = 1'b1;
      end
      begin
        while (!stopEn) begin
          @(posedge clk);
          #1 en0 = ($urandom_range(0, 3) != 0);
        end
      end
    join
    en0 = 1'b1;
    waitIdle(0);
    checkStream("random", 0, 1'b1);

    // Gap instance: LSB first with a 3-cycle idle gap between words
    @(posedge clk);
    #1 clearScoreboard();
    applyStimulus(1, 32'h0000_0001);
    applyStimulus(1, 32'h8000_0000);
    waitIdle(1);
    checkStream("gap lsb-first", 1, 1'b0);
    checkOutput("gap length", (q1.size() >= 33) ? q1[32].cyc - q1[31].cyc - 1 : -1, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
